// File: rtl/multicycle_ctrl.sv
// Multicycle processor controller: Moore main FSM, ALU decoder, condition
// check and NZCV flag register driving the datapath enables and selects.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  flags_q;
    logic        condex_q;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        unused_instr;

    logic        next_pc, ir_w, regw, memw, branch, aluop;
    logic        adr_src;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  alu_ctl;
    logic        flagw_nz, flagw_cv, pcs, cond_ok;

    assign cond         = Instr[31:28];
    assign op           = Instr[27:26];
    assign funct        = Instr[25:20];
    assign rd           = Instr[15:12];
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    // State, latched condition result and architectural flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                condex_q <= cond_ok;
            if (flagw_nz && condex_q)
                flags_q[3:2] <= ALUFlags[3:2];
            if (flagw_cv && condex_q)
                flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    // Next state and per-state Moore controls
    always_comb begin
        state_d    = state_q;
        next_pc    = 1'b0;
        ir_w       = 1'b0;
        regw       = 1'b0;
        memw       = 1'b0;
        branch     = 1'b0;
        aluop      = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                state_d    = S_DECODE;
                ir_w       = 1'b1;
                next_pc    = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_d   = funct[0] ? S_MEMREAD : S_MEMWRITE;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                state_d = S_MEMWB;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                state_d    = S_FETCH;
                result_src = 2'b01;
                regw       = 1'b1;
            end
            S_MEMWRITE: begin
                state_d = S_FETCH;
                adr_src = 1'b1;
                memw    = 1'b1;
            end
            S_EXECUTER: begin
                state_d = S_ALUWB;
                aluop   = 1'b1;
            end
            S_EXECUTEI: begin
                state_d   = S_ALUWB;
                alu_src_b = 2'b01;
                aluop     = 1'b1;
            end
            S_ALUWB: begin
                state_d = S_FETCH;
                // CMP only updates flags, never the register file
                regw    = (funct[4:1] != 4'b1010);
            end
            S_BRANCH: begin
                state_d    = S_FETCH;
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // ALU operation decode
    always_comb begin
        alu_ctl = ALU_ADD;
        if (aluop) begin
            case (funct[4:1])
                4'b0100: alu_ctl = ALU_ADD;
                4'b0010: alu_ctl = ALU_SUB;
                4'b0000: alu_ctl = ALU_AND;
                4'b1100: alu_ctl = ALU_ORR;
                4'b1010: alu_ctl = ALU_SUB;
                default: alu_ctl = ALU_ADD;
            endcase
        end
    end

    // Condition field against the current flag register {N,Z,C,V}
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = flags_q[2];
            4'b0001: cond_ok = !flags_q[2];
            4'b0010: cond_ok = flags_q[1];
            4'b0011: cond_ok = !flags_q[1];
            4'b0100: cond_ok = flags_q[3];
            4'b0101: cond_ok = !flags_q[3];
            4'b0110: cond_ok = flags_q[0];
            4'b0111: cond_ok = !flags_q[0];
            4'b1000: cond_ok = flags_q[1] && !flags_q[2];
            4'b1001: cond_ok = !flags_q[1] || flags_q[2];
            4'b1010: cond_ok = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ok = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ok = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'b1101: cond_ok = flags_q[2] || (flags_q[3] != flags_q[0]);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign flagw_nz = aluop && funct[0];
    assign flagw_cv = flagw_nz && ((alu_ctl == ALU_ADD) || (alu_ctl == ALU_SUB));
    assign pcs      = branch || (regw && (rd == 4'hF));

    // Write enables are gated off while reset is held
    assign PCWrite    = !reset && (next_pc || (pcs && condex_q));
    assign RegWrite   = !reset && regw && condex_q && !pcs;
    assign MemWrite   = !reset && memw && condex_q;
    assign IRWrite    = !reset && ir_w;
    assign AdrSrc     = adr_src;
    assign ALUSrcA    = alu_src_a;
    assign ALUSrcB    = alu_src_b;
    assign ResultSrc  = result_src;
    assign ALUControl = alu_ctl;
    assign ImmSrc     = op;
    assign RegSrc     = {(op == 2'b01) && !funct[0], op == 2'b10};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: an instruction-level model
// predicts every cycle's outputs; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3,
                   P_MEMWB = 4, P_MEMWRITE = 5, P_EXR = 6, P_EXI = 7,
                   P_ALUWB = 8, P_BRANCH = 9;

    typedef struct {
        logic [17:0] v;
        string       tag;
    } exp_t;

    exp_t        q[$];
    int          sched[$];
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  mflags;

    function automatic string pname(input int ph);
        case (ph)
            P_FETCH:    return "FETCH";
            P_DECODE:   return "DECODE";
            P_MEMADR:   return "MEMADR";
            P_MEMREAD:  return "MEMREAD";
            P_MEMWB:    return "MEMWB";
            P_MEMWRITE: return "MEMWRITE";
            P_EXR:      return "EXECUTER";
            P_EXI:      return "EXECUTEI";
            P_ALUWB:    return "ALUWB";
            default:    return "BRANCH";
        endcase
    endfunction

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] funct);
        case (funct[4:1])
            4'b0010, 4'b1010: return 3'b001;
            4'b0000:          return 3'b010;
            4'b1100:          return 3'b011;
            default:          return 3'b000;
        endcase
    endfunction

    // Outputs expected during one phase of instruction ins with condition result cx
    function automatic logic [17:0] expect_vec(input int ph, input logic [31:0] ins,
                                               input logic cx, input logic rst);
        logic [1:0] op;
        logic [5:0] funct;
        logic pcw, mw, rw, irw, adr, regw, memw, br, pcs;
        logic [1:0] sa, sb, res;
        logic [2:0] aluc;
        op = ins[27:26]; funct = ins[25:20];
        pcw = 0; irw = 0; adr = 0; regw = 0; memw = 0; br = 0;
        sa = 2'b00; sb = 2'b00; res = 2'b00; aluc = 3'b000;
        case (ph)
            P_FETCH:    begin irw = 1; pcw = 1; sa = 2'b01; sb = 2'b10; res = 2'b10; end
            P_DECODE:   begin sa = 2'b01; sb = 2'b10; res = 2'b10; end
            P_MEMADR:   sb = 2'b01;
            P_MEMREAD:  adr = 1;
            P_MEMWB:    begin res = 2'b01; regw = 1; end
            P_MEMWRITE: begin adr = 1; memw = 1; end
            P_EXR:      aluc = alu_of(funct);
            P_EXI:      begin sb = 2'b01; aluc = alu_of(funct); end
            P_ALUWB:    regw = (funct[4:1] != 4'b1010);
            default:    begin sa = 2'b10; sb = 2'b01; res = 2'b10; br = 1; end
        endcase
        pcs = br || (regw && ins[15:12] == 4'hF);
        pcw = pcw || (pcs && cx);
        rw  = regw && cx && !pcs;
        mw  = memw && cx;
        if (rst) begin pcw = 0; mw = 0; rw = 0; irw = 0; end
        return {pcw, mw, rw, irw, adr, {(op == 2'b01) && !funct[0], op == 2'b10},
                sa, sb, res, op, aluc};
    endfunction

    task automatic build_sched(input logic [31:0] ins);
        sched = {};
        sched.push_back(P_FETCH);
        sched.push_back(P_DECODE);
        case (ins[27:26])
            2'b00: begin sched.push_back(ins[25] ? P_EXI : P_EXR); sched.push_back(P_ALUWB); end
            2'b01: begin
                sched.push_back(P_MEMADR);
                if (ins[20]) begin sched.push_back(P_MEMREAD); sched.push_back(P_MEMWB); end
                else sched.push_back(P_MEMWRITE);
            end
            2'b10: sched.push_back(P_BRANCH);
            default: ;
        endcase
    endtask

    // Runs up to maxcyc phases of ins; entered and left at posedge+1
    task automatic run_instr(input logic [31:0] ins, input int maxcyc,
                             input logic [3:0] ff, input bit fen);
        logic cx;
        int n;
        cx = cond_holds(ins[31:28], mflags);
        build_sched(ins);
        n = (maxcyc < sched.size()) ? maxcyc : sched.size();
        Instr = ins;
        for (int i = 0; i < n; i++) begin
            ALUFlags = fen ? ff : 4'($urandom);
            q.push_back('{expect_vec(sched[i], ins, cx, 1'b0), pname(sched[i])});
            if ((sched[i] == P_EXR || sched[i] == P_EXI) && ins[20] && cx) begin
                mflags[3:2] = ALUFlags[3:2];
                if (alu_of(ins[25:20]) <= 3'b001) mflags[1:0] = ALUFlags[1:0];
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_cycle(input int ph);
        reset = 1'b1;
        ALUFlags = 4'($urandom);
        q.push_back('{expect_vec(ph, Instr, 1'b0, 1'b1), "reset"});
        @(posedge clk); #1;
        reset = 1'b0;
        mflags = 4'b0000;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [17:0] got;
            e = q.pop_front();
            got = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                   ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL %s @%0t instr=%h: got %b want %b", e.tag, $time, Instr, got, e.v);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        int cut;
        reset = 1'b1; Instr = 32'h0; ALUFlags = 4'h0; mflags = 4'h0;
        @(posedge clk); #1;
        reset_cycle(P_FETCH);

        run_instr(32'hE0821003, 99, 4'h0, 1'b0);  // ADD R1,R2,R3
        run_instr(32'hE2500001, 99, 4'b0100, 1'b1); // SUBS -> Z
        run_instr(32'h0A000002, 99, 4'h0, 1'b0);  // BEQ taken
        run_instr(32'hE2500001, 99, 4'b0000, 1'b1); // SUBS -> flags clear
        run_instr(32'h0A000002, 99, 4'h0, 1'b0);  // BEQ not taken
        run_instr(32'hE5902004, 99, 4'h0, 1'b0);  // LDR
        run_instr(32'hE5802008, 99, 4'h0, 1'b0);  // STR
        run_instr(32'hE2500001, 99, 4'b0100, 1'b1);
        run_instr(32'hE5902004, 3, 4'h0, 1'b0);   // stop in MEMREAD
        reset_cycle(P_MEMREAD);
        run_instr(32'h0A000002, 99, 4'h0, 1'b0);  // flags cleared: not taken

        for (int k = 0; k < 400; k++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) != 0) ins[31:28] = 4'hE;
            ins[15:12] = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            if ($urandom_range(0, 3) == 0) ins[24:21] = 4'b1010;
            if ($urandom_range(0, 40) == 0) begin
                build_sched(ins);
                cut = $urandom_range(0, sched.size() - 1);
                run_instr(ins, cut, 4'h0, 1'b0);
                build_sched(ins);
                reset_cycle(sched[cut]);
            end else begin
                run_instr(ins, 99, 4'h0, 1'b0);
            end
        end

        @(negedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
